fp_result_collector: RTL and testbench

FP_RESULT_COLLECTOR -- requirements
Module: fp_result_collector

---
 rtl/fp_result_collector.sv | 100 ++++++++++
 tb/tb_fp_result_collector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_collector.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fp_result_collector: captures each FP adder completion into a FWFT FIFO  |
// | with drop/overflow/underflow statistics.          Rev 1.0               |
// +-------------------------------------------------------------------------+
module fp_result_collector #(
  parameter int         DEPTH     = 8,
  parameter logic [2:0] DONE_CODE = 3'd4
) (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic [2:0]  res_phase,
  input  logic [31:0] res_data,
  input  logic [3:0]  res_status,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_status,
  output logic [4:0]  fifo_count,
  output logic [7:0]  drop_count,
  output logic [7:0]  ovf_count,
  output logic [7:0]  unf_count
);

  localparam int         ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] C_DEPTH = 5'(DEPTH);

  generate
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("fp_result_collector: DEPTH must be a power of two in 2..16");
    end
  endgenerate

  logic [35:0]       mem_q [DEPTH];
  logic              prev_done_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]        count_q, count_d;
  logic [7:0]        drop_q, drop_d;
  logic [7:0]        ovf_q, ovf_d;
  logic [7:0]        unf_q, unf_d;

  logic event_w, pop_w, push_w, drop_w;

  always_comb begin
    event_w  = (res_phase == DONE_CODE) && !prev_done_q;
    pop_w    = (count_q != 5'd0) && out_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    push_w   = event_w && ((count_q != C_DEPTH) || pop_w);
    drop_w   = event_w && !push_w;

    wr_ptr_d = push_w ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_w  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    count_d  = count_q;
    if (push_w && !pop_w)      count_d = count_q + 5'd1;
    else if (pop_w && !push_w) count_d = count_q - 5'd1;

    drop_d = drop_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (drop_w && drop_q != 8'hFF)                            drop_d = drop_q + 8'd1;
    if (event_w && res_status == 4'd1 && ovf_q != 8'hFF)      ovf_d  = ovf_q + 8'd1;
    if (event_w && res_status == 4'd2 && unf_q != 8'hFF)      unf_d  = unf_q + 8'd1;
  end

  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      // Held high so a phase already at DONE_CODE on release is not an event.
      prev_done_q <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      ovf_q       <= '0;
      unf_q       <= '0;
    end else begin
      prev_done_q <= (res_phase == DONE_CODE);
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge clock_100kHz) begin
    if (push_w && !reset) mem_q[wr_ptr_q] <= {res_status, res_data};
  end

  assign out_valid               = (count_q != 5'd0);
  assign {out_status, out_data}  = mem_q[rd_ptr_q];
  assign fifo_count              = count_q;
  assign drop_count              = drop_q;
  assign ovf_count               = ovf_q;
  assign unf_count               = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_result_collector.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | tb_fp_result_collector: directed stimulus with queue scoreboard.         |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_fp_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  res_phase = 3'd0;
  logic [31:0] res_data = 32'd0;
  logic [3:0]  res_status = 4'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_status;
  logic [4:0]  fifo_count;
  logic [7:0]  drop_count, ovf_count, unf_count;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q [$];

  always #5 clk = ~clk;

  fp_result_collector #(.DEPTH(8), .DONE_CODE(3'd4)) dut (
    .clock_100kHz(clk),
    .reset(reset),
    .res_phase(res_phase),
    .res_data(res_data),
    .res_status(res_status),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_status(out_status),
    .fifo_count(fifo_count),
    .drop_count(drop_count),
    .ovf_count(ovf_count),
    .unf_count(unf_count)
  );

  // Monitor: every accepted head entry is compared with the scoreboard front.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got status=%0d data=%h, expected no entry", out_status, out_data);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({out_status, out_data} !== e) begin
          errors++;
          $display("FAIL pop_entry: got status=%0d data=%h, expected status=%0d data=%h",
                   out_status, out_data, e[35:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // One completion: DONE_CODE for one cycle, then idle for one cycle.
  task automatic event_once(input logic [31:0] d, input logic [3:0] s, input bit stored);
    res_phase = 3'd4; res_data = d; res_status = s;
    if (stored) exp_q.push_back({s, d});
    step();
    res_phase = 3'd0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    step(); step();
    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_drop",  32'(drop_count), 32'd0);
    check("rst_ovf",   32'(ovf_count), 32'd0);
    check("rst_unf",   32'(unf_count), 32'd0);
    reset = 1'b0;
    step();

    // Single event with consumer ready: visible one cycle, then popped
    out_ready = 1'b1;
    res_phase = 3'd4; res_data = 32'h4A000000; res_status = 4'd0;
    exp_q.push_back({4'd0, 32'h4A000000});
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_count", 32'(fifo_count), 32'd1);
    res_phase = 3'd0;
    step();
    check("single_valid_after", 32'(out_valid), 32'd0);
    check("single_count_after", 32'(fifo_count), 32'd0);

    // DONE_CODE held 5 cycles yields one entry
    out_ready = 1'b0;
    res_phase = 3'd4; res_data = 32'h12345678; res_status = 4'd3;
    exp_q.push_back({4'd3, 32'h12345678});
    repeat (5) step();
    res_phase = 3'd0;
    step();
    check("held_count", 32'(fifo_count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("held_drained", 32'(fifo_count), 32'd0);

    // Fill past full: 9 events, 8 stored, 1 dropped
    for (int i = 1; i <= 9; i++) event_once(32'(i), 4'd0, i <= 8);
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_drop",  32'(drop_count), 32'd1);
    check("stable_data0", out_data, 32'd1);
    step();
    check("stable_data1", out_data, 32'd1);
    check("stable_status", 32'(out_status), 32'd0);

    // Full: event and pop in the same cycle
    out_ready = 1'b1;
    res_phase = 3'd4; res_data = 32'h0000000A; res_status = 4'd0;
    exp_q.push_back({4'd0, 32'h0000000A});
    step();
    out_ready = 1'b0; res_phase = 3'd0;
    check("fullpp_count", 32'(fifo_count), 32'd8);
    check("fullpp_drop",  32'(drop_count), 32'd1);
    step();
    out_ready = 1'b1;
    repeat (8) step();
    out_ready = 1'b0;
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // Status statistics
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) event_once(32'h80000000 | 32'(i), 4'd2, 1'b1);
    event_once(32'h7E000001, 4'd1, 1'b1);
    event_once(32'h00000055, 4'd5, 1'b1);
    event_once(32'h00000056, 4'd3, 1'b1);
    check("stat_unf", 32'(unf_count), 32'd3);
    check("stat_ovf", 32'(ovf_count), 32'd1);
    check("stat_drop", 32'(drop_count), 32'd1);
    out_ready = 1'b0;

    // 300 overflow events into a blocked FIFO
    reset = 1'b1; step(); step(); reset = 1'b0; step();
    for (int i = 0; i < 300; i++) event_once(32'h100 + 32'(i), 4'd1, i < 8);
    check("sat_count", 32'(fifo_count), 32'd8);
    check("sat_ovf",   32'(ovf_count), 32'd255);
    check("sat_unf",   32'(unf_count), 32'd0);
    check("sat_drop",  32'(drop_count), 32'd255);

    // Mid-stream reset with DONE_CODE held across release
    reset = 1'b1; res_phase = 3'd4; res_data = 32'hDEAD0000; res_status = 4'd1;
    exp_q.delete();
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    check("rel_count", 32'(fifo_count), 32'd0);
    check("rel_valid", 32'(out_valid), 32'd0);
    check("rel_ovf",   32'(ovf_count), 32'd0);
    check("rel_drop",  32'(drop_count), 32'd0);
    res_phase = 3'd0;
    step();
    res_phase = 3'd4; res_data = 32'h0000BEEF; res_status = 4'd2;
    exp_q.push_back({4'd2, 32'h0000BEEF});
    step();
    res_phase = 3'd0;
    step();
    check("reenter_count", 32'(fifo_count), 32'd1);
    check("reenter_unf",   32'(unf_count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("final_count", 32'(fifo_count), 32'd0);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
